// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, parity-engine state, parity helper reused by the TX serialiser.
// Pure definitions; no latency and no flow control of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        PM_NONE  = 3'd0,
        PM_EVEN  = 3'd1,
        PM_ODD   = 3'd2,
        PM_MARK  = 3'd3,
        PM_SPACE = 3'd4
    } parity_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam int MIN_DATA_BITS = 5;

    function automatic logic parity_from_acc(input logic acc, input parity_mode_e mode);
        logic p;
        case (mode)
            PM_EVEN:  p = acc;
            PM_ODD:   p = ~acc;
            PM_MARK:  p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    // Encodings 5..7 have no meaning on the line and behave as "no parity slot".
    function automatic parity_mode_e decode_mode(input logic [2:0] raw);
        parity_mode_e m;
        case (raw)
            3'd1:    m = PM_EVEN;
            3'd2:    m = PM_ODD;
            3'd3:    m = PM_MARK;
            3'd4:    m = PM_SPACE;
            default: m = PM_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_parity_engine.sv
// Serial parity generate/check engine: results one cycle after the final accepted bit, all outputs registered/state-decoded.
// One bit per cycle when bit_valid is high; bit_valid gaps simply stall the frame, frame_start always wins and restarts.
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter  int MAX_DATA_BITS = 9,
    parameter  int CNT_WIDTH     = 8,
    localparam int LEN_W         = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [2:0]           parity_mode,
    input  logic                 check_en,
    input  logic [LEN_W-1:0]     data_len,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 err_clear,
    output logic                 busy,
    output logic                 parity_ready,
    output logic                 parity_bit,
    output logic                 frame_done,
    output logic                 parity_error,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [LEN_W-1:0]     LEN_MIN = LEN_W'(MIN_DATA_BITS);
    localparam logic [LEN_W-1:0]     LEN_MAX = LEN_W'(MAX_DATA_BITS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [LEN_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    parity_mode_e         mode_q, mode_d;
    logic                 check_q, check_d;
    logic                 frame_done_q, frame_done_d;
    logic                 parity_error_q, parity_error_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 par_bit;

    assign par_bit = parity_from_acc(acc_q, mode_q);

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        bit_cnt_d      = bit_cnt_q;
        len_d          = len_q;
        mode_d         = mode_q;
        check_d        = check_q;
        frame_done_d   = 1'b0;
        parity_error_d = 1'b0;

        if (frame_start) begin
            state_d   = ST_DATA;
            acc_d     = 1'b0;
            bit_cnt_d = '0;
            mode_d    = decode_mode(parity_mode);
            check_d   = check_en;
            if (data_len < LEN_MIN) begin
                len_d = LEN_MIN;
            end else if (data_len > LEN_MAX) begin
                len_d = LEN_MAX;
            end else begin
                len_d = data_len;
            end
        end else if (bit_valid) begin
            case (state_q)
                ST_DATA: begin
                    acc_d     = acc_q ^ bit_in;
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    if (bit_cnt_d == len_q) begin
                        if (mode_q == PM_NONE) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    frame_done_d   = 1'b1;
                    parity_error_d = check_q && (bit_in != par_bit);
                    state_d        = ST_IDLE;
                end
                default: ;
            endcase
        end

        // err_clear in the cycle an error is being decided still counts that error.
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (err_clear) begin
            err_sticky_d = parity_error_d;
            err_count_d  = parity_error_d ? CNT_WIDTH'(1) : '0;
        end else if (parity_error_d) begin
            err_sticky_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            acc_q          <= 1'b0;
            bit_cnt_q      <= '0;
            len_q          <= LEN_MIN;
            mode_q         <= PM_NONE;
            check_q        <= 1'b0;
            frame_done_q   <= 1'b0;
            parity_error_q <= 1'b0;
            err_sticky_q   <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            bit_cnt_q      <= bit_cnt_d;
            len_q          <= len_d;
            mode_q         <= mode_d;
            check_q        <= check_d;
            frame_done_q   <= frame_done_d;
            parity_error_q <= parity_error_d;
            err_sticky_q   <= err_sticky_d;
            err_count_q    <= err_count_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign parity_ready = (state_q == ST_PARITY);
    assign parity_bit   = parity_ready & par_bit;
    assign frame_done   = frame_done_q;
    assign parity_error = parity_error_q;
    assign err_sticky   = err_sticky_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: directed frames push expected completions, a monitor checks every frame_done.
module tb_uart_parity_engine;

    localparam int MAXB  = 9;
    localparam int CNTW  = 2;
    localparam int LENW  = $clog2(MAXB + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_start, check_en, bit_valid, bit_in, err_clear;
    logic [2:0]      parity_mode;
    logic [LENW-1:0] data_len;
    logic            busy, parity_ready, parity_bit, frame_done, parity_error, err_sticky;
    logic [CNTW-1:0] err_count;

    uart_parity_engine #(.MAX_DATA_BITS(MAXB), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .parity_mode(parity_mode),
        .check_en(check_en), .data_len(data_len), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clear(err_clear), .busy(busy), .parity_ready(parity_ready), .parity_bit(parity_bit),
        .frame_done(frame_done), .parity_error(parity_error), .err_sticky(err_sticky),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        cyc;
        logic      rdy;
        logic      pbit;
        logic      perr;
        logic      sticky;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mcyc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic rdy, input logic pbit, input logic perr,
                                input logic sticky, input logic [1:0] cnt);
        exp_t e;
        e.cyc = 0; e.rdy = rdy; e.pbit = pbit; e.perr = perr; e.sticky = sticky; e.cnt = cnt;
        return e;
    endfunction

    // Monitor: samples on the falling edge, pops one expectation per frame_done.
    initial begin : monitor
        logic saw_rdy;
        logic got_pbit;
        exp_t e;
        saw_rdy  = 1'b0;
        got_pbit = 1'b0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                saw_rdy = 1'b0;
            end else begin
                if (parity_ready && !saw_rdy) begin
                    saw_rdy  = 1'b1;
                    got_pbit = parity_bit;
                end
                if (parity_error && !frame_done) check("perr_without_done", 1, 0);
                if (frame_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", mcyc, e.cyc);
                        check("saw_parity_ready", saw_rdy, e.rdy);
                        if (e.rdy) check("parity_bit", got_pbit, e.pbit);
                        check("parity_error", parity_error, e.perr);
                        check("err_sticky", err_sticky, e.sticky);
                        check("err_count", err_count, e.cnt);
                    end
                    saw_rdy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] mode, input logic chk, input logic [LENW-1:0] len);
        frame_start = 1'b1; parity_mode = mode; check_en = chk; data_len = len;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_valid = 1'b0;
        repeat (gap) tick();
        bit_valid = 1'b1; bit_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    // Full frame; e.rdy selects whether a parity slot is sent after the data bits.
    task automatic run_frame(input logic [2:0] mode, input logic chk, input logic [LENW-1:0] len,
                             input int nbits, input logic [15:0] data, input logic pin,
                             input int gap, input logic clr_last, input exp_t e);
        exp_t ee;
        ee = e;
        start(mode, chk, len);
        for (int i = 0; i < nbits; i++) begin
            if (i == nbits - 1 && !e.rdy) err_clear = clr_last;
            send_bit(data[i], gap);
        end
        if (e.rdy) begin
            check("pready_latency", parity_ready, 1);
            check("pbit_latency", parity_bit, e.pbit);
            err_clear = clr_last;
            send_bit(pin, gap);
        end
        err_clear = 1'b0;
        ee.cyc = mcyc + 1;
        sb.push_back(ee);
    endtask

    initial begin : watchdog
        #300000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : driver
        rst_n = 1'b0; frame_start = 1'b0; parity_mode = 3'd0; check_en = 1'b0;
        data_len = '0; bit_valid = 1'b0; bit_in = 1'b0; err_clear = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_pready", parity_ready, 0);
        check("rst_pbit", parity_bit, 0);
        check("rst_done", frame_done, 0);
        check("rst_perr", parity_error, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_count", err_count, 0);
        rst_n = 1'b1;
        tick();

        // bit_valid while idle must not start anything
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        check("idle_ignore_busy", busy, 0);

        run_frame(3'd1, 1'b0, 4'd8, 8, 16'h00A5, 1'b1, 0, 1'b0, mk(1, 0, 0, 0, 2'd0)); // EVEN tx
        run_frame(3'd2, 1'b1, 4'd8, 8, 16'h00A5, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd1)); // ODD rx bad
        run_frame(3'd0, 1'b0, 4'd7, 7, 16'h0055, 1'b0, 2, 1'b0, mk(0, 0, 0, 1, 2'd1)); // NONE, gaps
        run_frame(3'd3, 1'b1, 4'd2, 5, 16'h0016, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd2)); // MARK, clamp 5
        run_frame(3'd4, 1'b1, 4'd2, 5, 16'h0016, 1'b0, 0, 1'b0, mk(1, 0, 0, 1, 2'd2)); // SPACE
        run_frame(3'd1, 1'b1, 4'd15, 9, 16'h01FF, 1'b1, 1, 1'b0, mk(1, 1, 0, 1, 2'd2)); // clamp 9

        // abort after 4 bits; restart coincides with a bit_valid that must be dropped
        start(3'd1, 1'b1, 4'd8);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        bit_valid = 1'b1; bit_in = 1'b1;
        run_frame(3'd1, 1'b1, 4'd8, 8, 16'h0001, 1'b1, 0, 1'b0, mk(1, 1, 0, 1, 2'd2));

        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clear_sticky", err_sticky, 0);
        check("clear_count", err_count, 0);

        run_frame(3'd2, 1'b1, 4'd5, 5, 16'h0000, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd1));
        run_frame(3'd2, 1'b1, 4'd5, 5, 16'h0000, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd2));
        run_frame(3'd2, 1'b1, 4'd5, 5, 16'h0000, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd3));
        run_frame(3'd2, 1'b1, 4'd5, 5, 16'h0000, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd3));
        run_frame(3'd2, 1'b1, 4'd5, 5, 16'h0000, 1'b0, 0, 1'b0, mk(1, 1, 1, 1, 2'd3));
        run_frame(3'd2, 1'b1, 4'd5, 5, 16'h0000, 1'b0, 0, 1'b1, mk(1, 1, 1, 1, 2'd1)); // clear+err

        // reset while waiting in the parity slot
        start(3'd1, 1'b0, 4'd5);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        check("pre_reset_pready", parity_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_pready", parity_ready, 0);
        check("midrst_pbit", parity_bit, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_perr", parity_error, 0);
        check("midrst_sticky", err_sticky, 0);
        check("midrst_count", err_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_frame(3'd1, 1'b0, 4'd5, 5, 16'h0007, 1'b0, 0, 1'b0, mk(1, 1, 0, 0, 2'd0));
        repeat (4) tick();
        check("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised serial parity engine for the UART datapath, replacing the fixed 8-bit combinational generator/checker. It accumulates parity bit-by-bit as data bits are shifted, with a run-time data length and five parity modes. It serves the TX serialiser (generate mode) and the RX deserialiser (check mode). It adds frame sequencing, abort/restart, and sticky plus counted error reporting.

## Interface
- MAX_DATA_BITS, 9, largest supported data length; legal range 5..16
- CNT_WIDTH, 8, width of the saturating parity-error counter
- LEN_W (localparam), $clog2(MAX_DATA_BITS+1), width of data_len

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse; clears the accumulator, latches configuration, enters DATA
- parity_mode  in  3  latched at frame_start: 0 NONE, 1 EVEN, 2 ODD, 3 MARK, 4 SPACE; 5..7 treated as NONE
- check_en  in  1  latched at frame_start: 1 check (RX), 0 generate (TX)
- data_len  in  LEN_W  latched at frame_start; values below 5 clamp to 5, above MAX_DATA_BITS clamp to MAX_DATA_BITS
- bit_valid  in  1  one data or parity bit presented/consumed this cycle
- bit_in  in  1  serial bit (RX data/parity, TX data); ignored during TX parity slot
- err_clear  in  1  clears err_sticky and err_count
- busy  out  1  state != IDLE
- parity_ready  out  1  state == PARITY
- parity_bit  out  1  expected/generated parity bit; valid while parity_ready
- frame_done  out  1  one-cycle pulse at frame completion
- parity_error  out  1  one-cycle pulse, coincident with frame_done, on check mismatch
- err_sticky  out  1  set by any parity_error until err_clear
- err_count  out  CNT_WIDTH  saturating count of parity_error pulses

## Operation
- States: IDLE, DATA, PARITY.
- IDLE: on frame_start, go to DATA. Set acc=0 and bit_cnt=0. Latch mode, check_en and clamped len.
- DATA: on each bit_valid, set acc ^= bit_in and increment bit_cnt.
  - On the valid that makes bit_cnt == len: with mode NONE, pulse frame_done and return to IDLE.
  - Otherwise go to PARITY.
- PARITY: parity_bit is acc for EVEN, ~acc for ODD, 1 for MARK, 0 for SPACE.
  - On bit_valid, pulse frame_done and return to IDLE.
  - In check mode only, also pulse parity_error when bit_in != parity_bit.
- frame_start in DATA or PARITY aborts the current frame and restarts it with the new configuration. No frame_done is issued for the aborted frame; frame_start takes priority over a coincident bit_valid.
- bit_valid in IDLE is ignored.
- Error accounting:
  - err_sticky sets on parity_error.
  - err_count increments on parity_error and holds at 2^CNT_WIDTH-1.
  - err_clear coincident with parity_error gives err_sticky=1 and err_count=1.

## Timing
- Reset: state=IDLE, acc=0, bit_cnt=0; busy, parity_ready, parity_bit, frame_done, parity_error, err_sticky = 0; err_count = 0.
- All outputs are registered or decoded from registered state only, with no input-to-output combinational path.
- busy rises the cycle after frame_start.
- parity_ready/parity_bit are valid the cycle after the last data bit_valid.
- frame_done/parity_error assert the cycle after the final accepted bit, for exactly one cycle. err_sticky and err_count update in that same cycle.
- Back-to-back operation: frame_start may arrive in the same cycle frame_done is high, with no dead cycle.
- Throughput: one bit per cycle maximum. bit_valid gaps of any length are allowed.

## Structure
- The shared uart_pkg holds:
  - the parity_mode_e enum (NONE/EVEN/ODD/MARK/SPACE);
  - the state enum;
  - the function parity_from_acc(acc, mode), reused by the TX serialiser.
- Single module with no sub-module.
- LEN_W is derived locally.

## Test plan
- EVEN, generate mode, len 8, bits of 8'hA5 LSB-first -> parity_ready with parity_bit=0; one bit_valid later, frame_done pulses and parity_error stays 0.
- ODD, check mode, len 8, data 8'hA5 then parity bit 0 -> parity_error pulse with frame_done; err_sticky=1, err_count=1.
- NONE, len 7, 7 bits -> frame_done the cycle after the 7th bit; parity_ready never asserts.
- MARK/SPACE, check mode, len 5, received parity 0 -> error for MARK, no error for SPACE. data_len=2 clamps to 5; data_len=15 with MAX_DATA_BITS=9 clamps to 9.
- Abort: frame_start after 4 data bits, then full 8-bit EVEN frame 8'h01 with parity 1 -> a single frame_done, no error, and the acc result is unaffected by the aborted bits.
- CNT_WIDTH=2, 5 bad frames -> err_count saturates at 3. err_clear coincident with a 6th error -> err_count=1, err_sticky=1. Reset asserted mid-PARITY -> all outputs 0 and IDLE.
